data_memory: RTL and testbench
==============================

# data_memory

Byte-addressable data memory for the single-cycle RISC-V core. It executes SB/SH/SW stores on the clock edge and LB/LH/LW/LBU/LHU loads combinationally within the same cycle. It sits directly upstream of the write-back 3-input select mux and drives that mux's memory-data input; the other two inputs are the ALU result and PC+4. It also latches a sticky record of the first misaligned or illegal access for debug.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, at least 4.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- addr  in  32  byte address from the ALU.
- wr_data  in  32  store data from rs2.
- mem_write  in  1  store enable.
- mem_read  in  1  load enable.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rd_data  out  32  extended load data, to the write-back mux.
- misaligned  out  1  combinational: the current access is misaligned or illegal.
- err_sticky  out  1  set by the first bad access; cleared only by reset.
- err_addr  out  32  address of the first bad access.

## Operation
- Storage is DEPTH_WORDS x 32 bits, little-endian.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Byte lane is addr[1:0]. Half lane is addr[1].
- bad = (mem_read | mem_write) & (misaligned | illegal funct3).
  - Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=00.
  - Illegal funct3: 011, 110, 111, and 100/101 when storing.
- misaligned = bad. It is 0 whenever neither enable is asserted.
- Store: at the rising clk edge, if mem_write & !bad:
  - SB writes wr_data[7:0] into the addressed byte lane.
  - SH writes wr_data[15:0] into the addressed half lane.
  - SW writes all 32 bits.
  - Unaddressed lanes are unchanged.
- A bad store writes nothing.
- Load (combinational): if mem_read & !bad, rd_data is:
  - LB: the addressed byte, sign-extended.
  - LBU: the addressed byte, zero-extended.
  - LH/LHU: the addressed half, sign- or zero-extended.
  - LW: the whole word.
- rd_data = 0 when mem_read=0 or bad=1.
- mem_read and mem_write both high: the store is performed at the edge; rd_data shows the pre-write contents during that cycle.
- Error capture: at the rising edge, if bad & !err_sticky, then err_sticky <= 1 and err_addr <= addr. Later bad accesses do not change err_addr.
- Reset, asynchronous on rst rising, with no clock needed:
  - All memory words clear to 0.
  - err_sticky = 0, err_addr = 0.
  - Consequently rd_data = 0 and misaligned follows its inputs.
- While rst is high:
  - All stores are ignored.
  - Loads return 0.
  - err capture is blocked.

## Timing
- Load latency: 0 cycles. rd_data settles combinationally from addr/funct3/mem_read in the same cycle, so that the write-back mux and register file capture it at the end of that cycle.
- Store latency: 1 edge. Data is visible to a load in the cycle after the write edge, never in the same cycle (read-old-data).
- err_sticky/err_addr update one edge after the bad access.
- Reset deasserting near a clock edge: the first store honoured is at the first edge where rst is already low.

## Test plan
- Reset: assert rst mid-run after writing 0xDEADBEEF to addr 0x10, then release. Required: LW 0x10 gives 0; err_sticky=0; err_addr=0 immediately on rst rise.
- Byte/half stores and extended loads:
  - SW 0x8 = 0x11223344, then SB 0x9 = 0xF0. Required: LW 0x8 = 0x1122F044; LB 0x9 = 0xFFFFFFF0; LBU 0x9 = 0x000000F0.
  - SH 0xA = 0x8001. Required: LH 0xA = 0xFFFF8001; LHU 0xA = 0x00008001.
- Read-during-write: word at 0x20 holds 5; in the same cycle mem_read=mem_write=1, SW 0x20 = 7. Required: rd_data=5 that cycle and 7 the next cycle.
- Misaligned/illegal:
  - LW 0x22 gives misaligned=1 and rd_data=0.
  - SH 0x21 = 0xABCD leaves memory unchanged.
  - After the first error: err_sticky=1, err_addr=0x22. A later bad SW at 0x33 leaves err_addr=0x22.
- Wrap-around (DEPTH_WORDS=256): SW 0x400 = 0xCAFEF00D. Required: LW 0x0 = 0xCAFEF00D.
- Idle: mem_read=mem_write=0 with any addr/funct3. Required: rd_data=0, misaligned=0, no state change.

Source files
------------

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory for the single-cycle core.
// Stores commit on the clock edge; loads are combinational with sign/zero extension.
module data_memory #(
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   input  logic        mem_write,
   input  logic        mem_read,
   input  logic [2:0]  funct3,
   output logic [31:0] rd_data,
   output logic        misaligned,
   output logic        err_sticky,
   output logic [31:0] err_addr
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic [31:0]   cur_word;
   logic [31:0]   wr_word;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic          is_h;
   logic          is_w;
   logic          bad_align;
   logic          bad_f3;
   logic          bad;

   assign idx      = addr[AW+1:2];
   assign cur_word = mem[idx];
   assign rd_byte  = cur_word[{addr[1:0], 3'b000} +: 8];
   assign rd_half  = cur_word[{addr[1], 4'b0000} +: 16];

   // Access checks: alignment by size, plus reserved encodings and unsigned stores.
   assign is_h       = (funct3[1:0] == 2'b01);
   assign is_w       = (funct3[1:0] == 2'b10);
   assign bad_align  = (is_h & addr[0]) | (is_w & (addr[1:0] != 2'b00));
   assign bad_f3     = (funct3[1:0] == 2'b11) | (funct3 == 3'b110) | (funct3[2] & mem_write);
   assign bad        = (mem_read | mem_write) & (bad_align | bad_f3);
   assign misaligned = bad;

   // Merge store data into the addressed lanes of the current word.
   always_comb begin
      wr_word = cur_word;
      case (funct3[1:0])
         2'b00:   wr_word[{addr[1:0], 3'b000} +: 8] = wr_data[7:0];
         2'b01:   wr_word[{addr[1], 4'b0000} +: 16] = wr_data[15:0];
         2'b10:   wr_word = wr_data;
         default: wr_word = cur_word;
      endcase
   end

   always_comb begin
      rd_data = 32'h0;
      if (mem_read & !bad & !rst) begin
         case (funct3)
            3'b000:  rd_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rd_data = {24'h0, rd_byte};
            3'b001:  rd_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  rd_data = {16'h0, rd_half};
            3'b010:  rd_data = cur_word;
            default: rd_data = 32'h0;
         endcase
      end
   end

   // Storage and first-error capture; reset clears everything without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
            mem[i] <= 32'h0;
         end
         err_sticky <= 1'b0;
         err_addr   <= 32'h0;
      end else begin
         if (mem_write & !bad) begin
            mem[idx] <= wr_word;
         end
         if (bad & !err_sticky) begin
            err_sticky <= 1'b1;
            err_addr   <= addr;
         end
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: stores, extended loads,
// read-during-write, bad-access capture, address wrap and async reset.
module tb_data_memory;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic        mem_write;
   logic        mem_read;
   logic [2:0]  funct3;
   logic [31:0] rd_data;
   logic        misaligned;
   logic        err_sticky;
   logic [31:0] err_addr;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   data_memory #(.DEPTH_WORDS(256)) dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .wr_data    (wr_data),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .funct3     (funct3),
      .rd_data    (rd_data),
      .misaligned (misaligned),
      .err_sticky (err_sticky),
      .err_addr   (err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply inputs and let combinational outputs settle.
   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      mem_read  = rd;
      mem_write = wr;
      funct3    = f3;
      addr      = a;
      wr_data   = d;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, F_W, 32'h0, 32'h0);
      step();
      step();
      chk("reset_err_sticky", {31'h0, err_sticky}, 32'h0);
      chk("reset_err_addr", err_addr, 32'h0);
      chk("reset_rd_data", rd_data, 32'h0);
      rst = 1'b0;

      // Idle: no enables means no output and no error
      drive(1'b0, 1'b0, 3'b111, 32'h22, 32'hFFFF_FFFF);
      chk("idle_rd_data", rd_data, 32'h0);
      chk("idle_misaligned", {31'h0, misaligned}, 32'h0);
      step();
      chk("idle_no_err", {31'h0, err_sticky}, 32'h0);

      // Byte store into a word, then extended loads
      drive(1'b0, 1'b1, F_W, 32'h8, 32'h1122_3344);
      step();
      drive(1'b0, 1'b1, F_B, 32'h9, 32'h0000_00F0);
      step();
      drive(1'b1, 1'b0, F_W, 32'h8, 32'h0);
      chk("lw_after_sb", rd_data, 32'h1122_F044);
      drive(1'b1, 1'b0, F_B, 32'h9, 32'h0);
      chk("lb_sext", rd_data, 32'hFFFF_FFF0);
      drive(1'b1, 1'b0, F_BU, 32'h9, 32'h0);
      chk("lbu_zext", rd_data, 32'h0000_00F0);
      drive(1'b1, 1'b0, F_B, 32'hB, 32'h0);
      chk("lb_lane3", rd_data, 32'h0000_0011);

      // Upper-half store
      drive(1'b0, 1'b1, F_H, 32'hA, 32'hFFFF_8001);
      step();
      drive(1'b1, 1'b0, F_H, 32'hA, 32'h0);
      chk("lh_sext", rd_data, 32'hFFFF_8001);
      drive(1'b1, 1'b0, F_HU, 32'hA, 32'h0);
      chk("lhu_zext", rd_data, 32'h0000_8001);
      drive(1'b1, 1'b0, F_W, 32'h8, 32'h0);
      chk("lw_after_sh", rd_data, 32'h8001_F044);

      // Idle cycle with stray data must not write
      drive(1'b0, 1'b0, F_W, 32'h8, 32'h5555_5555);
      step();
      drive(1'b1, 1'b0, F_W, 32'h8, 32'h0);
      chk("idle_no_write", rd_data, 32'h8001_F044);

      // Read-during-write returns the old word
      drive(1'b0, 1'b1, F_W, 32'h20, 32'h5);
      step();
      drive(1'b1, 1'b1, F_W, 32'h20, 32'h7);
      chk("rdw_old", rd_data, 32'h5);
      step();
      drive(1'b1, 1'b0, F_W, 32'h20, 32'h0);
      chk("rdw_new", rd_data, 32'h7);

      // Misaligned load: flagged, zero data, captured one edge later
      drive(1'b1, 1'b0, F_W, 32'h22, 32'h0);
      chk("lw_mis_flag", {31'h0, misaligned}, 32'h1);
      chk("lw_mis_data", rd_data, 32'h0);
      chk("err_not_yet", {31'h0, err_sticky}, 32'h0);
      step();
      chk("err_sticky_set", {31'h0, err_sticky}, 32'h1);
      chk("err_addr_first", err_addr, 32'h22);

      // Misaligned half store writes nothing
      drive(1'b0, 1'b1, F_H, 32'h21, 32'h0000_ABCD);
      chk("sh_mis_flag", {31'h0, misaligned}, 32'h1);
      step();
      drive(1'b1, 1'b0, F_W, 32'h20, 32'h0);
      chk("sh_mis_nowrite", rd_data, 32'h7);

      // Later bad store keeps the first error address
      drive(1'b0, 1'b1, F_W, 32'h33, 32'h1234_5678);
      step();
      chk("err_addr_kept", err_addr, 32'h22);
      chk("err_sticky_kept", {31'h0, err_sticky}, 32'h1);

      // Unsigned store encoding is illegal and writes nothing
      drive(1'b0, 1'b1, F_BU, 32'h8, 32'h0000_0099);
      chk("sbu_illegal_flag", {31'h0, misaligned}, 32'h1);
      step();
      drive(1'b1, 1'b0, F_W, 32'h8, 32'h0);
      chk("sbu_nowrite", rd_data, 32'h8001_F044);

      // Reserved load encoding
      drive(1'b1, 1'b0, 3'b011, 32'h8, 32'h0);
      chk("f3_011_flag", {31'h0, misaligned}, 32'h1);
      chk("f3_011_data", rd_data, 32'h0);

      // Address wrap modulo 1 KiB
      drive(1'b0, 1'b1, F_W, 32'h400, 32'hCAFE_F00D);
      step();
      drive(1'b1, 1'b0, F_W, 32'h0, 32'h0);
      chk("wrap_lw0", rd_data, 32'hCAFE_F00D);

      // Asynchronous reset mid-cycle clears memory and error state
      drive(1'b0, 1'b1, F_W, 32'h10, 32'hDEAD_BEEF);
      step();
      drive(1'b1, 1'b0, F_W, 32'h10, 32'h0);
      chk("pre_reset_lw", rd_data, 32'hDEAD_BEEF);
      rst = 1'b1;
      #1;
      chk("async_rst_rd", rd_data, 32'h0);
      chk("async_rst_sticky", {31'h0, err_sticky}, 32'h0);
      chk("async_rst_addr", err_addr, 32'h0);
      drive(1'b0, 1'b1, F_W, 32'h14, 32'h0000_1234);
      step();
      drive(1'b1, 1'b0, F_W, 32'h22, 32'h0);
      chk("rst_mis_follows", {31'h0, misaligned}, 32'h1);
      step();
      chk("rst_blocks_capture", {31'h0, err_sticky}, 32'h0);
      rst = 1'b0;
      drive(1'b1, 1'b0, F_W, 32'h14, 32'h0);
      chk("rst_store_ignored", rd_data, 32'h0);
      drive(1'b1, 1'b0, F_W, 32'h10, 32'h0);
      chk("post_reset_lw", rd_data, 32'h0);
      drive(1'b1, 1'b0, F_W, 32'h0, 32'h0);
      chk("post_reset_wrap", rd_data, 32'h0);

      drive(1'b0, 1'b0, F_W, 32'h0, 32'h0);
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
